// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-lite definitions for the APB bridge.
// Holds HTRANS/HSIZE/HRESP encodings, the bridge state type, and apb_pstrb(),
// which turns an AHB size plus the low address bits into APB byte strobes and a
// flag saying whether the size/alignment pair is legal.
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_ERR1   = 3'd3,
        ST_ERR2   = 3'd4
    } apb_bridge_state_t;

    typedef struct packed {
        logic       legal;
        logic [3:0] strb;
    } apb_pstrb_t;

    function automatic apb_pstrb_t apb_pstrb(input logic [2:0] hsize, input logic [1:0] addr);
        apb_pstrb_t r;
        r.legal = 1'b0;
        r.strb  = 4'h0;
        case (hsize)
            HSIZE_BYTE: begin
                r.legal = 1'b1;
                r.strb  = 4'b0001 << addr;
            end
            HSIZE_HALF: begin
                r.legal = ~addr[0];
                r.strb  = 4'b0011 << {addr[1], 1'b0};
            end
            HSIZE_WORD: begin
                r.legal = (addr == 2'b00);
                r.strb  = 4'hF;
            end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ahb3lite_apb_bridge_if.sv
// Bus bundle between an AHB3-lite interconnect slave port and one APB3 segment.
// slave  : the bridge's view (AHB slave side in, APB master side out).
// master : the environment's view (drives AHB requests and APB responses).
interface ahb3lite_apb_bridge_if #(
    parameter int APB_AW = 16
);
    // AHB side
    logic              HSEL;
    logic              HWRITE;
    logic [31:0]       HADDR;
    logic [31:0]       HWDATA;
    logic [1:0]        HTRANS;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [3:0]        HPROT;
    logic              HREADY;
    logic [31:0]       HRDATA;
    logic              HREADYOUT;
    logic              HRESP;
    // APB side
    logic [APB_AW-1:0] PADDR;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [31:0]       PWDATA;
    logic [3:0]        PSTRB;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport slave (
        input  HSEL, HWRITE, HADDR, HWDATA, HTRANS, HSIZE, HBURST, HPROT, HREADY,
        output HRDATA, HREADYOUT, HRESP,
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport master (
        output HSEL, HWRITE, HADDR, HWDATA, HTRANS, HSIZE, HBURST, HPROT, HREADY,
        input  HRDATA, HREADYOUT, HRESP,
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/ahb3lite_apb_bridge.sv
// AHB3-lite slave to APB3 master bridge.
// Each accepted AHB beat becomes one APB SETUP/ACCESS pair; PSLVERR, a PREADY
// timeout, or an illegal size/alignment produce the two-cycle AHB ERROR response.
// Ports:
//   CLK   - single clock for both buses
//   RESET - synchronous, active-high
//   bus   - ahb3lite_apb_bridge_if.slave (AHB slave + APB master signals)
// Parameters:
//   APB_AW  - APB address width (must match the interface)
//   TIMEOUT - ACCESS cycles with PREADY low before abort; 0 disables
module ahb3lite_apb_bridge
    import ahb3lite_pkg::*;
#(
    parameter int APB_AW  = 16,
    parameter int TIMEOUT = 255
) (
    input logic                  CLK,
    input logic                  RESET,
    ahb3lite_apb_bridge_if.slave bus
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    apb_bridge_state_t state_q, state_d;
    logic [APB_AW-1:0] addr_q;
    logic              write_q;
    logic [3:0]        strb_q;
    logic [31:0]       pwdata_q;
    logic [31:0]       hrdata_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    apb_pstrb_t chk;
    logic       accept;
    logic       addr_phase_ok;
    logic       take;
    logic [CNT_W-1:0] cnt_inc;
    logic       timeout_hit;
    logic       unused_sigs;

    assign chk     = apb_pstrb(bus.HSIZE, bus.HADDR[1:0]);
    assign accept  = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    // Only IDLE and ERR2 drive HREADYOUT high, so only they can own an address phase.
    assign addr_phase_ok = (state_q == ST_IDLE) || (state_q == ST_ERR2);
    assign take    = addr_phase_ok & accept;
    assign cnt_inc = cnt_q + 1'b1;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == TIMEOUT_CNT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                state_d = ST_IDLE;
                if (take) begin
                    if (chk.legal) begin
                        state_d = ST_SETUP;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_ERR1;
                    end
                end
            end
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (bus.PREADY) begin
                    state_d = bus.PSLVERR ? ST_ERR1 : ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (timeout_hit) begin
                        state_d = ST_ERR1;
                    end
                end
            end
            ST_ERR1:   state_d = ST_ERR2;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            strb_q   <= 4'h0;
            pwdata_q <= 32'h0;
            hrdata_q <= 32'h0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (take) begin
                addr_q  <= {bus.HADDR[APB_AW-1:2], 2'b00};
                write_q <= bus.HWRITE;
                strb_q  <= bus.HWRITE ? chk.strb : 4'h0;
            end
            // SETUP is the AHB data phase of the accepted beat.
            if (state_q == ST_SETUP) begin
                pwdata_q <= bus.HWDATA;
            end
            if ((state_q == ST_ACCESS) && bus.PREADY && !bus.PSLVERR && !write_q) begin
                hrdata_q <= bus.PRDATA;
            end
        end
    end

    assign bus.HREADYOUT = addr_phase_ok;
    assign bus.HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR
                                                                           : HRESP_OKAY;
    assign bus.HRDATA    = hrdata_q;
    assign bus.PSEL      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign bus.PENABLE   = (state_q == ST_ACCESS);
    assign bus.PWRITE    = write_q;
    assign bus.PADDR     = addr_q;
    assign bus.PSTRB     = strb_q;
    // Forward HWDATA during SETUP so PWDATA is valid for the whole APB transfer.
    assign bus.PWDATA    = (state_q == ST_SETUP) ? bus.HWDATA : pwdata_q;

    assign unused_sigs = ^{bus.HADDR[31:APB_AW], bus.HTRANS[0], bus.HBURST, bus.HPROT};

endmodule

// File: tb/tb_ahb3lite_apb_bridge.sv
// Directed self-checking bench for ahb3lite_apb_bridge.
module tb_ahb3lite_apb_bridge;

    logic CLK = 1'b0;
    logic RESET;
    int   n_cmp = 0;
    int   n_err = 0;

    ahb3lite_apb_bridge_if #(.APB_AW(16)) bus ();

    ahb3lite_apb_bridge #(.APB_AW(16), .TIMEOUT(255)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    // Single slave on the bus: HREADY follows this slave's HREADYOUT.
    assign bus.HREADY = bus.HREADYOUT;

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drives one NONSEQ address phase, then the data phase HWDATA.
    task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz,
                              input logic [31:0] wd);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HADDR  = a;
        bus.HWRITE = w;
        bus.HSIZE  = sz;
        tick();
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWDATA = wd;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick();
        tick();
        n_cmp++; if (bus.HREADYOUT !== 1'b1) begin n_err++; $display("FAIL rst_hreadyout got %b want 1", bus.HREADYOUT); end
        n_cmp++; if (bus.HRESP !== 1'b0) begin n_err++; $display("FAIL rst_hresp got %b want 0", bus.HRESP); end
        n_cmp++; if (bus.HRDATA !== 32'h0) begin n_err++; $display("FAIL rst_hrdata got %h want 0", bus.HRDATA); end
        n_cmp++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b000) begin n_err++; $display("FAIL rst_apbctl got %b want 000", {bus.PSEL, bus.PENABLE, bus.PWRITE}); end
        n_cmp++; if (bus.PADDR !== 16'h0) begin n_err++; $display("FAIL rst_paddr got %h want 0", bus.PADDR); end
        n_cmp++; if (bus.PWDATA !== 32'h0) begin n_err++; $display("FAIL rst_pwdata got %h want 0", bus.PWDATA); end
        n_cmp++; if (bus.PSTRB !== 4'h0) begin n_err++; $display("FAIL rst_pstrb got %h want 0", bus.PSTRB); end
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_word_write();
        int n = 0;
        int psel_n = 0;
        bus.PREADY = 1'b1; bus.PSLVERR = 1'b0;
        addr_phase(32'h0000_1234, 1'b1, 3'd2, 32'hDEAD_BEEF);
        n_cmp++; if (bus.PADDR !== 16'h1234) begin n_err++; $display("FAIL wr_paddr got %h want 1234", bus.PADDR); end
        n_cmp++; if (bus.PSTRB !== 4'hF) begin n_err++; $display("FAIL wr_pstrb got %h want f", bus.PSTRB); end
        n_cmp++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b101) begin n_err++; $display("FAIL wr_setup_ctl got %b want 101", {bus.PSEL, bus.PENABLE, bus.PWRITE}); end
        while (bus.HREADYOUT === 1'b0 && n < 20) begin
            n++;
            if (bus.PSEL === 1'b1) psel_n++;
            if (bus.PENABLE === 1'b1) begin
                n_cmp++; if (bus.PWDATA !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_pwdata got %h want deadbeef", bus.PWDATA); end
            end
            tick();
        end
        n_cmp++; if (n != 2) begin n_err++; $display("FAIL wr_wait got %0d want 2", n); end
        n_cmp++; if (psel_n != 2) begin n_err++; $display("FAIL wr_psel_cycles got %0d want 2", psel_n); end
        n_cmp++; if (bus.HRESP !== 1'b0) begin n_err++; $display("FAIL wr_hresp got %b want 0", bus.HRESP); end
        n_cmp++; if (bus.PSEL !== 1'b0) begin n_err++; $display("FAIL wr_psel_end got %b want 0", bus.PSEL); end
    endtask

    task automatic test_byte_read_wait();
        int n = 0;
        int acc = 0;
        bus.PREADY = 1'b0;
        bus.PRDATA = 32'h1122_3344;
        addr_phase(32'h0000_5003, 1'b0, 3'd0, 32'h0);
        n_cmp++; if (bus.PADDR !== 16'h5000) begin n_err++; $display("FAIL rd_paddr got %h want 5000", bus.PADDR); end
        n_cmp++; if (bus.PSTRB !== 4'h0) begin n_err++; $display("FAIL rd_pstrb got %h want 0", bus.PSTRB); end
        while (bus.HREADYOUT === 1'b0 && n < 50) begin
            n++;
            if (bus.PENABLE === 1'b1) begin
                acc++;
                bus.PREADY = (acc == 5);
            end
            tick();
        end
        bus.PREADY = 1'b1;
        n_cmp++; if (n != 6) begin n_err++; $display("FAIL rd_wait got %0d want 6", n); end
        n_cmp++; if (bus.HRDATA !== 32'h1122_3344) begin n_err++; $display("FAIL rd_hrdata got %h want 11223344", bus.HRDATA); end
        n_cmp++; if (bus.HRESP !== 1'b0) begin n_err++; $display("FAIL rd_hresp got %b want 0", bus.HRESP); end
    endtask

    task automatic test_pslverr();
        bus.PREADY = 1'b1; bus.PSLVERR = 1'b1;
        addr_phase(32'h0000_2000, 1'b1, 3'd2, 32'h5555_AAAA);
        tick();
        n_cmp++; if (bus.PENABLE !== 1'b1) begin n_err++; $display("FAIL slverr_access got %b want 1", bus.PENABLE); end
        tick();
        bus.PSLVERR = 1'b0;
        n_cmp++; if ({bus.HRESP, bus.HREADYOUT, bus.PSEL} !== 3'b100) begin n_err++; $display("FAIL slverr_err1 got %b want 100", {bus.HRESP, bus.HREADYOUT, bus.PSEL}); end
        tick();
        n_cmp++; if ({bus.HRESP, bus.HREADYOUT} !== 2'b11) begin n_err++; $display("FAIL slverr_err2 got %b want 11", {bus.HRESP, bus.HREADYOUT}); end
        bus.PRDATA = 32'hCAFE_F00D;
        addr_phase(32'h0000_3004, 1'b0, 3'd2, 32'h0);
        n_cmp++; if ({bus.PSEL, bus.PENABLE, bus.HRESP} !== 3'b100) begin n_err++; $display("FAIL slverr_next_setup got %b want 100", {bus.PSEL, bus.PENABLE, bus.HRESP}); end
        n_cmp++; if (bus.PADDR !== 16'h3004) begin n_err++; $display("FAIL slverr_next_paddr got %h want 3004", bus.PADDR); end
        tick();
        tick();
        n_cmp++; if (bus.HRDATA !== 32'hCAFE_F00D) begin n_err++; $display("FAIL slverr_next_hrdata got %h want cafef00d", bus.HRDATA); end
        n_cmp++; if (bus.HREADYOUT !== 1'b1) begin n_err++; $display("FAIL slverr_next_done got %b want 1", bus.HREADYOUT); end
    endtask

    task automatic test_illegal();
        logic psel_seen = 1'b0;
        addr_phase(32'h0000_0101, 1'b1, 3'd1, 32'h0);
        psel_seen |= bus.PSEL;
        n_cmp++; if ({bus.HRESP, bus.HREADYOUT} !== 2'b10) begin n_err++; $display("FAIL ill_half_err1 got %b want 10", {bus.HRESP, bus.HREADYOUT}); end
        tick();
        psel_seen |= bus.PSEL;
        n_cmp++; if ({bus.HRESP, bus.HREADYOUT} !== 2'b11) begin n_err++; $display("FAIL ill_half_err2 got %b want 11", {bus.HRESP, bus.HREADYOUT}); end
        addr_phase(32'h0000_0010, 1'b0, 3'd3, 32'h0);
        psel_seen |= bus.PSEL;
        n_cmp++; if ({bus.HRESP, bus.HREADYOUT} !== 2'b10) begin n_err++; $display("FAIL ill_size_err1 got %b want 10", {bus.HRESP, bus.HREADYOUT}); end
        tick();
        psel_seen |= bus.PSEL;
        tick();
        n_cmp++; if ({bus.HRESP, bus.HREADYOUT} !== 2'b01) begin n_err++; $display("FAIL ill_idle got %b want 01", {bus.HRESP, bus.HREADYOUT}); end
        n_cmp++; if (psel_seen !== 1'b0) begin n_err++; $display("FAIL ill_psel got %b want 0", psel_seen); end
    endtask

    task automatic test_timeout();
        int n = 0;
        int acc = 0;
        bus.PREADY = 1'b0;
        addr_phase(32'h0000_0040, 1'b1, 3'd2, 32'h0BAD_0BAD);
        while (bus.HRESP === 1'b0 && n < 400) begin
            n++;
            if (bus.PENABLE === 1'b1) acc++;
            tick();
        end
        n_cmp++; if (acc != 255) begin n_err++; $display("FAIL to_access_cycles got %0d want 255", acc); end
        n_cmp++; if ({bus.PSEL, bus.PENABLE, bus.HREADYOUT} !== 3'b000) begin n_err++; $display("FAIL to_err1 got %b want 000", {bus.PSEL, bus.PENABLE, bus.HREADYOUT}); end
        tick();
        n_cmp++; if ({bus.HRESP, bus.HREADYOUT} !== 2'b11) begin n_err++; $display("FAIL to_err2 got %b want 11", {bus.HRESP, bus.HREADYOUT}); end
        tick();
        bus.PREADY = 1'b1;
    endtask

    task automatic test_reset_mid();
        bus.PREADY = 1'b0;
        addr_phase(32'h0000_0080, 1'b1, 3'd2, 32'h1);
        tick();
        tick();
        n_cmp++; if (bus.PENABLE !== 1'b1) begin n_err++; $display("FAIL rmid_access got %b want 1", bus.PENABLE); end
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        bus.PREADY = 1'b1;
        n_cmp++; if ({bus.PSEL, bus.PENABLE, bus.HREADYOUT, bus.HRESP} !== 4'b0010) begin n_err++; $display("FAIL rmid_drop got %b want 0010", {bus.PSEL, bus.PENABLE, bus.HREADYOUT, bus.HRESP}); end
        addr_phase(32'h0000_008A, 1'b1, 3'd0, 32'h00AB_0000);
        n_cmp++; if (bus.PSTRB !== 4'b0100) begin n_err++; $display("FAIL rmid_pstrb got %b want 0100", bus.PSTRB); end
        n_cmp++; if (bus.PADDR !== 16'h0088) begin n_err++; $display("FAIL rmid_paddr got %h want 0088", bus.PADDR); end
        tick();
        n_cmp++; if (bus.PWDATA !== 32'h00AB_0000) begin n_err++; $display("FAIL rmid_pwdata got %h want 00ab0000", bus.PWDATA); end
        tick();
        n_cmp++; if ({bus.HREADYOUT, bus.HRESP} !== 2'b10) begin n_err++; $display("FAIL rmid_done got %b want 10", {bus.HREADYOUT, bus.HRESP}); end
    endtask

    task automatic test_back_to_back();
        bus.PREADY = 1'b1;
        bus.PRDATA = 32'h7766_5544;
        addr_phase(32'h0000_008E, 1'b1, 3'd1, 32'hBEEF_0000);
        n_cmp++; if (bus.PSTRB !== 4'b1100) begin n_err++; $display("FAIL b2b_half_pstrb got %b want 1100", bus.PSTRB); end
        tick();
        tick();
        // Completing cycle: next address phase goes out with no bubble.
        n_cmp++; if (bus.HREADYOUT !== 1'b1) begin n_err++; $display("FAIL b2b_complete got %b want 1", bus.HREADYOUT); end
        addr_phase(32'h0000_0090, 1'b0, 3'd2, 32'h0);
        n_cmp++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PSTRB} !== 7'b100_0000) begin n_err++; $display("FAIL b2b_rd_setup got %b want 1000000", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PSTRB}); end
        tick();
        tick();
        n_cmp++; if (bus.HRDATA !== 32'h7766_5544) begin n_err++; $display("FAIL b2b_rd_hrdata got %h want 77665544", bus.HRDATA); end
    endtask

    initial begin
        RESET       = 1'b1;
        bus.HSEL    = 1'b0;
        bus.HWRITE  = 1'b0;
        bus.HADDR   = 32'h0;
        bus.HWDATA  = 32'h0;
        bus.HTRANS  = 2'b00;
        bus.HSIZE   = 3'd0;
        bus.HBURST  = 3'd0;
        bus.HPROT   = 4'h0;
        bus.PRDATA  = 32'h0;
        bus.PREADY  = 1'b1;
        bus.PSLVERR = 1'b0;

        test_reset();
        test_word_write();
        test_byte_read_wait();
        test_pslverr();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
